rob_commit: RTL and testbench

- Reorder buffer plus in-order commit stage for the Tomasulo core; it sits on the opposite end of the ROB from issue.
- Issue allocates entries at the tail. The execution units write results back by ROB index.
- The block retires the head entry in program order, one instruction per cycle, and drives the register-bank write port.
- It detects taken branches at commit and flushes all speculative state.

---
 rtl/rob_commit.sv | 230 +++++++++++++++++++++++
 tb/tb_rob_commit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// ---------------------------------------------------------------------------
// rob_commit
//
// Reorder buffer with an in-order commit stage for the Tomasulo core.
// Issue allocates entries at the tail, execution units write results back
// by ROB index, and the head entry retires in program order at up to one
// instruction per cycle. The retiring instruction drives the register-bank
// write port, or the LSQ for a store. A taken branch at retirement flushes
// every speculative entry. Branches are statically predicted not-taken.
//
// Optional build macro:
//   ROB_WB_BYPASS_EN - A writeback aimed at a busy, not-yet-ready head entry
//                      retires that entry on the same edge, using
//                      wb_data/wb_taken directly.
//
// Ports:
//   clk1          core clock; all state updates on the rising edge
//   rst           asynchronous active-high reset
//   alloc_valid   issue requests a new entry this cycle
//   alloc_func    opcode of the issued instruction
//   alloc_rd      destination register (a branch's immediate; not used)
//   alloc_ready   an entry is free (count < DEPTH); combinational
//   alloc_idx     ROB index that an allocation receives (tail); combinational
//   wb_valid      execution-unit result valid
//   wb_idx        ROB index being written back
//   wb_data       result value (store data for a store)
//   wb_taken      branch outcome
//   commit_valid  one-cycle pulse: an instruction retired
//   commit_wen    register-bank write enable for the retired instruction
//   commit_rd     destination register of the retired instruction
//   commit_data   retired value
//   commit_idx    ROB index that retired
//   commit_store  the retired instruction is a store
//   flush         one-cycle pulse when a taken branch retires
//   count         number of occupied entries
// ---------------------------------------------------------------------------
module rob_commit #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_func,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_taken,
  output logic              commit_valid,
  output logic              commit_wen,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [IDX_W-1:0]  commit_idx,
  output logic              commit_store,
  output logic              flush,
  output logic [IDX_W:0]    count
);

  localparam logic [3:0]     FUNC_STORE = 4'b0101;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0] CNT_ONE    = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] CNT_FULL   = (IDX_W+1)'(DEPTH);

  // Opcodes that write an architectural register: add, sub, mul, div, load.
  function automatic logic writes_reg(input logic [3:0] f);
    logic r;
    case (f)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: r = 1'b1;
      default:                                     r = 1'b0;
    endcase
    return r;
  endfunction

  // Opcodes that are conditional branches: beq, bneq.
  function automatic logic is_branch(input logic [3:0] f);
    logic r;
    case (f)
      4'b0110, 4'b0111: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  // Per-entry state
  logic [DEPTH-1:0]  ent_busy;
  logic [DEPTH-1:0]  ent_ready;
  logic [DEPTH-1:0]  ent_taken;
  logic [3:0]        ent_func [DEPTH];
  logic [REG_W-1:0]  ent_rd   [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;

  // Decisions for the coming edge
  logic              do_commit;
  logic              do_flush;
  logic              do_alloc;
  logic              do_wb;
  logic [3:0]        c_func;
  logic [DATA_W-1:0] c_data;
  logic              c_taken;

  assign alloc_ready = (count < CNT_FULL);
  assign alloc_idx   = tail;

  // Decide what retires, whether it flushes, and which updates survive.
  always_comb begin
    do_commit = 1'b0;
    c_func    = ent_func[head];
    c_data    = ent_data[head];
    c_taken   = ent_taken[head];
    if (ent_busy[head] && ent_ready[head]) begin
      do_commit = 1'b1;
`ifdef ROB_WB_BYPASS_EN
    end else if (ent_busy[head] && wb_valid && (wb_idx == head)) begin
      // The result arrives for the head entry: retire it on this edge.
      do_commit = 1'b1;
      c_data    = wb_data;
      c_taken   = wb_taken;
`endif
    end else begin
      do_commit = 1'b0;
    end
    do_flush = do_commit && is_branch(c_func) && c_taken;
    // A flush discards any allocation or writeback on the same edge.
    do_alloc = alloc_valid && alloc_ready && !do_flush;
    // A writeback to the retiring head is dropped; the entry is being freed.
    do_wb    = wb_valid && ent_busy[wb_idx] && !do_flush &&
               !(do_commit && (wb_idx == head));
  end

  // Entry state: allocation, writeback, retirement and flush.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      ent_busy  <= '0;
      ent_ready <= '0;
      ent_taken <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_func[i] <= 4'b0000;
        ent_rd[i]   <= '0;
        ent_data[i] <= '0;
      end
    end else if (do_flush) begin
      ent_busy  <= '0;
      ent_ready <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_alloc && (tail == IDX_W'(i))) begin
          ent_busy[i]  <= 1'b1;
          ent_ready[i] <= 1'b0;
          ent_func[i]  <= alloc_func;
          ent_rd[i]    <= alloc_rd;
        end else if (do_commit && (head == IDX_W'(i))) begin
          ent_busy[i]  <= 1'b0;
          ent_ready[i] <= 1'b0;
        end else if (do_wb && (wb_idx == IDX_W'(i))) begin
          ent_ready[i] <= 1'b1;
          ent_data[i]  <= wb_data;
          ent_taken[i] <= wb_taken;
        end else begin
          ent_busy[i]  <= ent_busy[i];
          ent_ready[i] <= ent_ready[i];
        end
      end
    end
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (do_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_commit) begin
        head <= head + IDX_ONE;
      end else begin
        head <= head;
      end
      if (do_alloc) begin
        tail <= tail + IDX_ONE;
      end else begin
        tail <= tail;
      end
      case ({do_alloc, do_commit})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Registered commit port; payload fields hold when nothing retires.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_wen   <= 1'b0;
      commit_store <= 1'b0;
      commit_rd    <= '0;
      commit_data  <= '0;
      commit_idx   <= '0;
      flush        <= 1'b0;
    end else begin
      commit_valid <= do_commit;
      commit_wen   <= do_commit && writes_reg(c_func);
      commit_store <= do_commit && (c_func == FUNC_STORE);
      flush        <= do_flush;
      if (do_commit) begin
        commit_rd   <= ent_rd[head];
        commit_data <= c_data;
        commit_idx  <= head;
      end else begin
        commit_rd   <= commit_rd;
        commit_data <= commit_data;
        commit_idx  <= commit_idx;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// ---------------------------------------------------------------------------
// tb_rob_commit
//
// Self-checking bench for rob_commit. A program-order queue model predicts
// every commit-port value and the occupancy. Directed scenarios run first,
// followed by a randomized stream.
// ---------------------------------------------------------------------------
module tb_rob_commit;

  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  logic              clk1 = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic [3:0]        alloc_func;
  logic [REG_W-1:0]  alloc_rd;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx;
  logic              wb_valid;
  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              wb_taken;
  logic              commit_valid;
  logic              commit_wen;
  logic [REG_W-1:0]  commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [IDX_W-1:0]  commit_idx;
  logic              commit_store;
  logic              flush;
  logic [IDX_W:0]    count;

  rob_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk1(clk1), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data), .wb_taken(wb_taken),
    .commit_valid(commit_valid), .commit_wen(commit_wen), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_idx(commit_idx), .commit_store(commit_store),
    .flush(flush), .count(count)
  );

  always #5 clk1 = ~clk1;

  // Reference model: in-flight instructions in program order.
  typedef struct {
    int idx;
    int func;
    int rd;
    int data;
    bit ready;
    bit taken;
  } ent_t;

  ent_t q[$];
  int   m_head;
  int   e_valid, e_wen, e_store, e_flush, e_rd, e_data, e_idx;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head  = 0;
    e_valid = 0; e_wen = 0; e_store = 0; e_flush = 0;
    e_rd    = 0; e_data = 0; e_idx = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cvalid"}, commit_valid, 1'b0);
    check({tag, "_cwen"},   commit_wen,   1'b0);
    check({tag, "_cstore"}, commit_store, 1'b0);
    check({tag, "_flush"},  flush,        1'b0);
    check({tag, "_cdata"},  commit_data,  16'h0000);
    check({tag, "_cidx"},   commit_idx,   3'd0);
    check({tag, "_count"},  count,        4'd0);
    check({tag, "_aready"}, alloc_ready,  1'b1);
    check({tag, "_aidx"},   alloc_idx,    3'd0);
  endtask

  // One clock cycle: drive inputs (called at a falling edge), check the
  // combinational outputs, advance the model, then check after the edge.
  task automatic step(input bit av, input int af, input int ard,
                      input bit wv, input int wi, input int wd, input bit wt);
    bit   com;
    ent_t h;
    ent_t n;
    alloc_valid = av;
    alloc_func  = af[3:0];
    alloc_rd    = ard[REG_W-1:0];
    wb_valid    = wv;
    wb_idx      = wi[IDX_W-1:0];
    wb_data     = wd[DATA_W-1:0];
    wb_taken    = wt;
    #1;
    check("alloc_ready", alloc_ready, (q.size() < DEPTH));
    check("alloc_idx",   alloc_idx,   (m_head + q.size()) % DEPTH);
    check("count_pre",   count,       q.size());

    com = 1'b0;
    if (q.size() > 0) begin
      h = q[0];
      if (h.ready) begin
        com = 1'b1;
`ifdef ROB_WB_BYPASS_EN
      end else if (wv && (wi == h.idx)) begin
        com = 1'b1;
        h.data  = wd;
        h.taken = wt;
`endif
      end
    end
    e_valid = com; e_wen = 0; e_store = 0; e_flush = 0;
    if (com) begin
      e_wen   = (h.func <= 4);
      e_store = (h.func == 5);
      e_flush = (h.func == 6 || h.func == 7) && h.taken;
      e_rd    = h.rd;
      e_data  = h.data & 16'hFFFF;
      e_idx   = h.idx;
    end
    if (e_flush) begin
      q.delete();
      m_head = 0;
    end else begin
      if (wv) begin
        foreach (q[k]) begin
          if (q[k].idx == wi && !(com && k == 0)) begin
            q[k].ready = 1'b1;
            q[k].data  = wd;
            q[k].taken = wt;
          end
        end
      end
      if (av && q.size() < DEPTH) begin
        n.idx = (m_head + q.size()) % DEPTH;
        n.func = af; n.rd = ard; n.data = 0; n.ready = 1'b0; n.taken = 1'b0;
        q.push_back(n);
      end
      if (com) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
    end

    @(posedge clk1);
    #1;
    check("commit_valid", commit_valid, e_valid);
    check("commit_wen",   commit_wen,   e_wen);
    check("commit_store", commit_store, e_store);
    check("flush",        flush,        e_flush);
    check("commit_rd",    commit_rd,    e_rd);
    check("commit_data",  commit_data,  e_data);
    check("commit_idx",   commit_idx,   e_idx);
    check("count_post",   count,        q.size());
    @(negedge clk1);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    @(negedge clk1);
    rst = 1'b0;
  endtask

  int wi;

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_func = 4'd0; alloc_rd = '0;
    wb_valid = 1'b0; wb_idx = '0; wb_data = '0; wb_taken = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk1);
    rst = 1'b0;

    // add rd=3 at idx0, writeback 0x00AB, retire one edge later
    step(1'b1, 0, 3, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 0, 16'h00AB, 1'b0);
    idle();
    check("tp1_valid", commit_valid, 1'b1);
    check("tp1_wen",   commit_wen,   1'b1);
    check("tp1_rd",    commit_rd,    4'd3);
    check("tp1_data",  commit_data,  16'h00AB);
    check("tp1_idx",   commit_idx,   3'd0);
    check("tp1_count", count,        4'd0);
    idle();
    check("tp1_hold_valid", commit_valid, 1'b0);
    check("tp1_hold_data",  commit_data,  16'h00AB);

    // three ops at idx1..3, writeback out of order, commits stay in order
    step(1'b1, 1, 4, 1'b0, 0, 0, 1'b0);
    step(1'b1, 2, 5, 1'b0, 0, 0, 1'b0);
    step(1'b1, 0, 6, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 3, 16'h0333, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1, 16'h0111, 1'b0);
    step(1'b0, 0, 0, 1'b1, 2, 16'h0222, 1'b0);
    check("tp2_first", commit_idx, 3'd1);
    idle();
    check("tp2_second", commit_idx, 3'd2);
    check("tp2_second_v", commit_valid, 1'b1);
    idle();
    check("tp2_third", commit_idx, 3'd3);
    check("tp2_third_d", commit_data, 16'h0333);

    // fill all eight entries, ignored 9th alloc, retire+alloc while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 0, i, 1'b0, 0, 0, 1'b0);
    #1;
    check("tp3_full_ready", alloc_ready, 1'b0);
    check("tp3_full_count", count, 4'd8);
    step(1'b1, 1, 9, 1'b1, 0, 16'h0F00, 1'b0);
    step(1'b1, 1, 9, 1'b0, 0, 0, 1'b0);
    check("tp3_count_same", count, 4'd7);
    step(1'b1, 2, 10, 1'b0, 0, 0, 1'b0);
    check("tp3_count_full", count, 4'd8);
    check("tp3_tail_wrap", alloc_idx, 3'd1);

    // store retires to the LSQ, not the register bank
    do_reset();
    step(1'b1, 5, 0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 0, 16'h1234, 1'b0);
    idle();
    check("tp4_store", commit_store, 1'b1);
    check("tp4_wen",   commit_wen,   1'b0);
    check("tp4_data",  commit_data,  16'h1234);

    // taken beq at idx1 with younger entries idx2..4 in flight
    do_reset();
    step(1'b1, 0, 1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 6, 0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 0, 2, 1'b0, 0, 0, 1'b0);
    step(1'b1, 0, 3, 1'b0, 0, 0, 1'b0);
    step(1'b1, 0, 4, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1, 16'h0001, 1'b1);
    step(1'b0, 0, 0, 1'b1, 0, 16'h0050, 1'b0);
    step(1'b1, 0, 7, 1'b1, 2, 16'h0002, 1'b0);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    check("tp5_flush", flush, 1'b1);
    check("tp5_wen",   commit_wen, 1'b0);
    check("tp5_count", count, 4'd0);
    check("tp5_aidx",  alloc_idx, 3'd0);
    step(1'b0, 0, 0, 1'b1, 3, 16'h0BAD, 1'b0);
    check("tp5_flush_pulse", flush, 1'b0);
    idle();
    check("tp5_no_commit", commit_valid, 1'b0);

    // asynchronous reset mid-stream with five entries in flight
    for (int i = 0; i < 6; i++) step(1'b1, 2, i, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 0, 16'h0777, 1'b0);
    idle();
    check("tp6_pre_valid", commit_valid, 1'b1);
    check("tp6_pre_count", count, 4'd5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("tp6_async");
    model_reset();
    @(negedge clk1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, i, 16'h0099, 1'b1);

    // randomized stream
    for (int n = 0; n < 600; n++) begin
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        wi = q[$urandom_range(0, q.size() - 1)].idx;
      else
        wi = $urandom_range(0, DEPTH - 1);
      step($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 15),
           $urandom_range(0, 9) < 7, wi, $urandom_range(0, 16'hFFFF),
           $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
